// File: rtl/icache_fill_ctrl_if.sv
// Bundle between the IF stage, the instruction cache and the multi-cycle main memory.
// fsm_state mirrors the fill controller state for checkers: 0 = IDLE, 1 = FILL.
interface icache_fill_ctrl_if;
  // Fetch side: when req_en is high, instr_out is consumed only if stall is low.
  // Memory side: mem_en is a one-cycle read request that is always accepted, and
  // mem_data_valid marks one returned word, with responses in request order.
  logic        req_en;
  logic [15:0] req_addr;
  logic [15:0] instr_out;
  logic        stall;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic        mem_data_valid;
  logic        fsm_state;

  modport master (
    output req_en, req_addr, mem_data_in, mem_data_valid,
    input  instr_out, stall, mem_en, mem_addr, fsm_state
  );

  modport slave (
    input  req_en, req_addr, mem_data_in, mem_data_valid,
    output instr_out, stall, mem_en, mem_addr, fsm_state
  );
endinterface

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache. Hits are served in the same cycle, and misses stall the fetch
// while the whole line is streamed in from a fixed-latency, in-order memory.
module icache_fill_ctrl #(
  parameter int BLOCKS  = 32,
  parameter int WORDS   = 8,
  parameter int MEM_LAT = 4
) (
  input logic               clk,
  input logic               rst,
  icache_fill_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(BLOCKS);
  localparam int OFF_W = $clog2(WORDS);
  localparam int TAG_W = 15 - IDX_W - OFF_W;
  localparam int CNT_W = OFF_W + 1;

  if (MEM_LAT < 1) begin : g_lat_check
    $error("icache_fill_ctrl: MEM_LAT must be at least 1");
  end

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t           state;
  logic [TAG_W-1:0] fill_tag;
  logic [IDX_W-1:0] fill_index;
  logic [CNT_W-1:0] issue_cnt;
  logic [OFF_W-1:0] recv_cnt;
  logic [BLOCKS-1:0] valid;

  logic [15:0]      data_mem [BLOCKS*WORDS];
  logic [TAG_W-1:0] tag_mem  [BLOCKS];

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_index;
  logic [OFF_W-1:0] req_word;
  logic             hit;
  logic             fill_write;
  logic             last_word;

  assign req_tag   = bus.req_addr[15 -: TAG_W];
  assign req_index = bus.req_addr[OFF_W+1 +: IDX_W];
  assign req_word  = bus.req_addr[1 +: OFF_W];

  assign hit        = bus.req_en & valid[req_index] & (tag_mem[req_index] == req_tag);
  assign fill_write = (state == FILL) & bus.mem_data_valid & ~rst;
  assign last_word  = (recv_cnt == OFF_W'(WORDS - 1));

  // The output is forced to zero whenever the fetch is stalled, so a stalled consumer never sees stale line data.
  assign bus.stall     = (state == FILL) | (bus.req_en & ~hit);
  assign bus.instr_out = ((state == IDLE) && hit) ? data_mem[{req_index, req_word}] : 16'h0000;
  assign bus.fsm_state = state;

  always_ff @(posedge clk) begin
    if (fill_write) begin
      data_mem[{fill_index, recv_cnt}] <= bus.mem_data_in;
      if (last_word) begin
        tag_mem[fill_index] <= fill_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      valid        <= '0;
      issue_cnt    <= '0;
      recv_cnt     <= '0;
      fill_tag     <= '0;
      fill_index   <= '0;
      bus.mem_en   <= 1'b0;
      bus.mem_addr <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          bus.mem_en <= 1'b0;
          if (bus.req_en && !hit) begin
            // The victim line is invalidated up front, so a partially overwritten line can never hit.
            state             <= FILL;
            fill_tag          <= req_tag;
            fill_index        <= req_index;
            valid[req_index]  <= 1'b0;
            bus.mem_en        <= 1'b1;
            bus.mem_addr      <= {req_tag, req_index, OFF_W'(0), 1'b0};
            issue_cnt         <= CNT_W'(1);
            recv_cnt          <= '0;
          end
        end
        FILL: begin
          if (issue_cnt < CNT_W'(WORDS)) begin
            bus.mem_en   <= 1'b1;
            bus.mem_addr <= {fill_tag, fill_index, issue_cnt[OFF_W-1:0], 1'b0};
            issue_cnt    <= issue_cnt + CNT_W'(1);
          end else begin
            bus.mem_en <= 1'b0;
          end
          // Completion is driven by the responses rather than by a cycle count, so latency jitter is tolerated.
          if (bus.mem_data_valid) begin
            recv_cnt <= recv_cnt + OFF_W'(1);
            if (last_word) begin
              valid[fill_index] <= 1'b1;
              state             <= IDLE;
              issue_cnt         <= '0;
              recv_cnt          <= '0;
              bus.mem_en        <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: a fixed-latency memory responder, a timeline-based cache model
// checked on every cycle, and hand-computed expectations for stall lengths, fill addresses and fetched words.
module tb_icache_fill_ctrl;
  localparam int MEM_LAT  = 4;
  localparam int WORDS    = 8;
  localparam int FILL_LEN = 1 + WORDS + MEM_LAT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_fill_ctrl_if bus();

  icache_fill_ctrl #(.BLOCKS(32), .WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Model: line ownership plus the position inside the miss timeline.
  bit          valid_m [32];
  logic [6:0]  tag_m   [32];
  int          fill_start = -1;
  logic [15:0] fill_base  = 16'h0000;

  // Memory responder: requested addresses and the cycle each response is due.
  logic [15:0] addr_q [$];
  int          due_q  [$];

  // Running observations of the DUT, read as differences from a mark.
  int          stall_cnt  = 0;
  int          mem_en_cnt = 0;
  logic [15:0] addr_log [$];
  int          mark_stall, mark_en, mark_addr;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return 16'h1000 + {1'b0, a[15:1]};
  endfunction

  function automatic bit model_hit(input logic en, input logic [15:0] a);
    return en && valid_m[a[8:4]] && (tag_m[a[8:4]] == a[15:9]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory responder + model update ----------------
  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      addr_q.push_back(bus.mem_addr);
      due_q.push_back(cyc + MEM_LAT);
    end
    if (rst) begin
      foreach (valid_m[i]) valid_m[i] = 1'b0;
      fill_start = -1;
    end else if (fill_start >= 0) begin
      if (cyc - fill_start == FILL_LEN - 1) begin
        valid_m[fill_base[8:4]] = 1'b1;
        tag_m[fill_base[8:4]]   = fill_base[15:9];
        fill_start = -1;
      end
    end else if (bus.req_en && !model_hit(bus.req_en, bus.req_addr)) begin
      fill_start = cyc;
      fill_base  = {bus.req_addr[15:4], 4'h0};
    end
    cyc++;
    #1;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      bus.mem_data_valid = 1'b1;
      bus.mem_data_in    = mem_fn(addr_q.pop_front());
      void'(due_q.pop_front());
    end else begin
      bus.mem_data_valid = 1'b0;
      bus.mem_data_in    = 16'hdead;
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(negedge clk) begin
    logic [15:0] e_instr, e_addr;
    logic        e_stall, e_en;
    int          k;
    if (chk_en) begin
      if (fill_start >= 0) begin
        k       = cyc - fill_start;
        e_stall = 1'b1;
        e_instr = 16'h0000;
        e_en    = (k >= 1) && (k <= WORDS);
        e_addr  = fill_base + 16'(2 * (k - 1));
      end else begin
        e_stall = bus.req_en && !model_hit(bus.req_en, bus.req_addr);
        e_instr = model_hit(bus.req_en, bus.req_addr) ? mem_fn({bus.req_addr[15:1], 1'b0}) : 16'h0000;
        e_en    = 1'b0;
        e_addr  = 16'h0000;
      end
      check("stall", 32'(bus.stall), 32'(e_stall));
      check("instr_out", 32'(bus.instr_out), 32'(e_instr));
      check("mem_en", 32'(bus.mem_en), 32'(e_en));
      check("fsm_state", 32'(bus.fsm_state), 32'(fill_start >= 0));
      if (e_en) check("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
      if (bus.stall) stall_cnt++;
      if (bus.mem_en) begin
        mem_en_cnt++;
        addr_log.push_back(bus.mem_addr);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic en, input logic [15:0] a);
    @(posedge clk);
    #1;
    bus.req_en   = en;
    bus.req_addr = a;
  endtask

  task automatic mark();
    mark_stall = stall_cnt;
    mark_en    = mem_en_cnt;
    mark_addr  = addr_log.size();
  endtask

  task automatic wait_unstall(input string name);
    int n = 0;
    while (bus.stall === 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_unstall"}, 32'(bus.stall), 32'd0);
  endtask

  // Present a fetch and hold it until the cache serves it; returns at negedge+1 of the serving cycle.
  task automatic fetch_wait(input logic [15:0] a, input string name);
    step(1'b1, a);
    mark();
    @(negedge clk);
    #1;
    wait_unstall(name);
  endtask

  task automatic check_fill_addrs(input string name, input logic [15:0] base);
    check({name, "_req_count"}, 32'(addr_log.size() - mark_addr), 32'd8);
    for (int i = 0; i < 8 && (mark_addr + i) < addr_log.size(); i++)
      check({name, "_req_addr"}, 32'(addr_log[mark_addr + i]), 32'(base + 16'(2 * i)));
  endtask

  // ---------------- directed sequence ----------------
  logic [15:0] tbl_addr  [6] = '{16'h0040, 16'h0046, 16'h1230, 16'h1232, 16'h0040, 16'h3FFE};
  logic [15:0] tbl_instr [6] = '{16'h1020, 16'h1023, 16'h1918, 16'h1919, 16'h1020, 16'h2FFF};
  int          tbl_stall [6] = '{13, 0, 13, 0, 0, 13};

  initial begin
    rst          = 1'b1;
    bus.req_en   = 1'b0;
    bus.req_addr = 16'h0040;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    mark();

    // Idle after reset, with a cold address presented but req_en low.
    repeat (3) begin
      @(negedge clk);
      #1;
      check("reset_stall", 32'(bus.stall), 32'd0);
      check("reset_mem_en", 32'(bus.mem_en), 32'd0);
      check("reset_instr", 32'(bus.instr_out), 32'd0);
      check("reset_state", 32'(bus.fsm_state), 32'd0);
    end
    check("noreq_mem_en_count", 32'(mem_en_cnt - mark_en), 32'd0);

    // Cold miss at 0x0000.
    step(1'b1, 16'h0000);
    mark();
    @(negedge clk);
    #1;
    check("cold_stall_c0", 32'(bus.stall), 32'd1);
    check("cold_mem_en_c0", 32'(bus.mem_en), 32'd0);
    wait_unstall("cold");
    check("cold_stall_len", 32'(stall_cnt - mark_stall), 32'd13);
    check_fill_addrs("cold", 16'h0000);
    check("cold_instr", 32'(bus.instr_out), 32'h1000);

    // Hit stream across the rest of the line.
    mark();
    for (int k = 1; k < 8; k++) begin
      step(1'b1, 16'(2 * k));
      @(negedge clk);
      #1;
      check("seq_instr", 32'(bus.instr_out), 32'(16'h1000 + 16'(k)));
    end
    check("seq_stall_count", 32'(stall_cnt - mark_stall), 32'd0);
    check("seq_mem_en_count", 32'(mem_en_cnt - mark_en), 32'd0);

    // Conflict on index 0, then back to the original line.
    fetch_wait(16'h0200, "conflict");
    check("conflict_stall_len", 32'(stall_cnt - mark_stall), 32'd13);
    check_fill_addrs("conflict", 16'h0200);
    check("conflict_instr", 32'(bus.instr_out), 32'h1100);
    fetch_wait(16'h0000, "refill");
    check("refill_stall_len", 32'(stall_cnt - mark_stall), 32'd13);
    check_fill_addrs("refill", 16'h0000);
    check("refill_instr", 32'(bus.instr_out), 32'h1000);

    // Mixed table of misses and hits on other indices.
    for (int i = 0; i < 6; i++) begin
      fetch_wait(tbl_addr[i], "table");
      check("table_stall_len", 32'(stall_cnt - mark_stall), 32'(tbl_stall[i]));
      check("table_instr", 32'(bus.instr_out), 32'(tbl_instr[i]));
    end

    // Reset in fill cycle 6 of a miss on 0x0200.
    step(1'b1, 16'h0200);
    repeat (5) step(1'b1, 16'h0200);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    bus.req_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_stall", 32'(bus.stall), 32'd0);
    check("midrst_mem_en", 32'(bus.mem_en), 32'd0);
    check("midrst_state", 32'(bus.fsm_state), 32'd0);
    mark();
    repeat (8) step(1'b0, 16'h0000);
    check("late_resp_stall_count", 32'(stall_cnt - mark_stall), 32'd0);
    check("late_resp_mem_en_count", 32'(mem_en_cnt - mark_en), 32'd0);
    fetch_wait(16'h0000, "post_rst_0000");
    check("post_rst_0000_stall_len", 32'(stall_cnt - mark_stall), 32'd13);
    check("post_rst_0000_instr", 32'(bus.instr_out), 32'h1000);
    fetch_wait(16'h0040, "post_rst_0040");
    check("post_rst_0040_stall_len", 32'(stall_cnt - mark_stall), 32'd13);
    check("post_rst_0040_instr", 32'(bus.instr_out), 32'h1020);

    step(1'b0, 16'h0000);
    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
